microblaze_bram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares a single port of the MicroBlaze 32 KB local BRAM block between two bus-side masters. Each master issues single-word read or byte-enabled write transactions through a request/acknowledge handshake. The arbiter sequences one BRAM access at a time, absorbs the one-cycle BRAM read latency, and returns registered read data. Addresses outside the memory range are rejected with an error acknowledge and never reach the BRAM.

---
 rtl/microblaze_bram_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_microblaze_bram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microblaze_bram_port_arbiter.sv
// microblaze_bram_port_arbiter
// Round-robin arbiter sharing one port of the MicroBlaze local BRAM between
// two request/acknowledge masters. One access is in flight at a time; each
// access walks IDLE -> ISSUE -> CAPTURE. Out-of-range accesses never enable
// the BRAM and complete with an error acknowledge.
module microblaze_bram_port_arbiter #(
  parameter int unsigned C_MEMSIZE     = 32'h0000_8000,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     M0_Req,
  input  logic [C_NUM_WE-1:0]      M0_WE,
  input  logic [C_PORT_AWIDTH-1:0] M0_Addr,
  input  logic [C_PORT_DWIDTH-1:0] M0_WData,
  output logic                     M0_Ack,
  output logic                     M0_Err,
  output logic [C_PORT_DWIDTH-1:0] M0_RData,
  input  logic                     M1_Req,
  input  logic [C_NUM_WE-1:0]      M1_WE,
  input  logic [C_PORT_AWIDTH-1:0] M1_Addr,
  input  logic [C_PORT_DWIDTH-1:0] M1_WData,
  output logic                     M1_Ack,
  output logic                     M1_Err,
  output logic [C_PORT_DWIDTH-1:0] M1_RData,
  output logic                     BRAM_EN,
  output logic [C_NUM_WE-1:0]      BRAM_WEN,
  output logic [C_PORT_AWIDTH-1:0] BRAM_Addr,
  output logic [C_PORT_DWIDTH-1:0] BRAM_Dout,
  input  logic [C_PORT_DWIDTH-1:0] BRAM_Din
);

  localparam logic [C_PORT_AWIDTH-1:0] MEM_LIMIT = C_PORT_AWIDTH'(C_MEMSIZE);
  localparam logic [C_NUM_WE-1:0]      WE_NONE   = {C_NUM_WE{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } state_t;

  // True when a byte address falls outside the BRAM.
  function automatic logic addr_out_of_range(input logic [C_PORT_AWIDTH-1:0] addr);
    return (addr >= MEM_LIMIT);
  endfunction

  logic [1:0]               rst_sync_r;
  logic                     rst_n_s;
  state_t                   state_r;
  logic                     last_grant_r;  // 0 = M0, 1 = M1
  logic                     gnt_id_r;
  logic [C_NUM_WE-1:0]      we_r;
  logic                     oor_r;

  logic                     elig0_s;
  logic                     elig1_s;
  logic                     grant_valid_s;
  logic                     grant_id_s;
  logic [C_NUM_WE-1:0]      sel_we_s;
  logic [C_PORT_AWIDTH-1:0] sel_addr_s;
  logic [C_PORT_DWIDTH-1:0] sel_wdata_s;
  logic                     sel_oor_s;

  // Reset asserts immediately and releases two rising edges after BRAM_Rst_N rises.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Pick a requester: a master being acknowledged this cycle sits out, ties go to the one not granted last.
  always_comb begin
    elig0_s       = M0_Req & ~M0_Ack;
    elig1_s       = M1_Req & ~M1_Ack;
    grant_valid_s = elig0_s | elig1_s;
    if (elig0_s && elig1_s) begin
      grant_id_s = ~last_grant_r;
    end else if (elig1_s) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Route the chosen master's qualifiers and range-check its address.
  always_comb begin
    if (grant_id_s) begin
      sel_we_s    = M1_WE;
      sel_addr_s  = M1_Addr;
      sel_wdata_s = M1_WData;
    end else begin
      sel_we_s    = M0_WE;
      sel_addr_s  = M0_Addr;
      sel_wdata_s = M0_WData;
    end
    sel_oor_s = addr_out_of_range(sel_addr_s);
  end

  // Transaction sequencer; every output is a register driven from here.
  always_ff @(posedge BRAM_Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      gnt_id_r     <= 1'b0;
      we_r         <= WE_NONE;
      oor_r        <= 1'b0;
      BRAM_EN      <= 1'b0;
      BRAM_WEN     <= WE_NONE;
      BRAM_Addr    <= {C_PORT_AWIDTH{1'b0}};
      BRAM_Dout    <= {C_PORT_DWIDTH{1'b0}};
      M0_Ack       <= 1'b0;
      M0_Err       <= 1'b0;
      M0_RData     <= {C_PORT_DWIDTH{1'b0}};
      M1_Ack       <= 1'b0;
      M1_Err       <= 1'b0;
      M1_RData     <= {C_PORT_DWIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          M0_Ack <= 1'b0;
          M0_Err <= 1'b0;
          M1_Ack <= 1'b0;
          M1_Err <= 1'b0;
          if (grant_valid_s) begin
            gnt_id_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
            we_r         <= sel_we_s;
            oor_r        <= sel_oor_s;
            BRAM_EN      <= ~sel_oor_s;
            BRAM_WEN     <= sel_oor_s ? WE_NONE : sel_we_s;
            BRAM_Addr    <= {sel_addr_s[C_PORT_AWIDTH-1:2], 2'b00};
            BRAM_Dout    <= sel_wdata_s;
            state_r      <= ST_ISSUE;
          end else begin
            BRAM_EN  <= 1'b0;
            BRAM_WEN <= WE_NONE;
            state_r  <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          BRAM_EN  <= 1'b0;
          BRAM_WEN <= WE_NONE;
          state_r  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          BRAM_EN  <= 1'b0;
          BRAM_WEN <= WE_NONE;
          if (gnt_id_r) begin
            M1_Ack <= 1'b1;
            M1_Err <= oor_r;
            if (!oor_r && (we_r == WE_NONE)) begin
              M1_RData <= BRAM_Din;
            end
          end else begin
            M0_Ack <= 1'b1;
            M0_Err <= oor_r;
            if (!oor_r && (we_r == WE_NONE)) begin
              M0_RData <= BRAM_Din;
            end
          end
          state_r <= ST_IDLE;
        end
        default: begin
          BRAM_EN  <= 1'b0;
          BRAM_WEN <= WE_NONE;
          M0_Ack   <= 1'b0;
          M0_Err   <= 1'b0;
          M1_Ack   <= 1'b0;
          M1_Err   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microblaze_bram_port_arbiter.sv
// Testbench for microblaze_bram_port_arbiter: BRAM port model, per-master
// scoreboards filled from a word-level memory model, and a negedge monitor.
module tb_microblaze_bram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        bram_en;
  logic [3:0]  bram_wen;
  logic [31:0] bram_addr, bram_dout, bram_din;

  int vectors     = 0;
  int miscompares = 0;
  bit contend     = 1'b0;

  typedef struct {
    logic        err;
    logic        is_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bram_mem [0:8191];

  microblaze_bram_port_arbiter dut (
    .BRAM_Clk  (clk),
    .BRAM_Rst_N(rst_n),
    .M0_Req    (m0_req),
    .M0_WE     (m0_we),
    .M0_Addr   (m0_addr),
    .M0_WData  (m0_wdata),
    .M0_Ack    (m0_ack),
    .M0_Err    (m0_err),
    .M0_RData  (m0_rdata),
    .M1_Req    (m1_req),
    .M1_WE     (m1_we),
    .M1_Addr   (m1_addr),
    .M1_WData  (m1_wdata),
    .M1_Ack    (m1_ack),
    .M1_Err    (m1_err),
    .M1_RData  (m1_rdata),
    .BRAM_EN   (bram_en),
    .BRAM_WEN  (bram_wen),
    .BRAM_Addr (bram_addr),
    .BRAM_Dout (bram_dout),
    .BRAM_Din  (bram_din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 'h%08h, want 'h%08h", name, act, exp);
    end
  endtask

  // Reference memory: word-addressed, byte-lane writes, zero where never written.
  function automatic exp_t model_xact(input logic [3:0] we, input logic [31:0] addr,
                                      input logic [31:0] wd);
    exp_t        e;
    int unsigned w;
    logic [31:0] word;
    e.err   = (addr >= 32'h0000_8000);
    e.is_rd = (we == 4'h0);
    e.rdata = 32'h0;
    if (!e.err) begin
      w    = addr / 4;
      word = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
      if (e.is_rd) begin
        e.rdata = word;
      end else begin
        for (int b = 0; b < 4; b++)
          if (we[b]) word[8*b +: 8] = wd[8*b +: 8];
        ref_mem[w] = word;
      end
    end
    return e;
  endfunction

  // Single-port BRAM: read-before-write, data valid the cycle after an enabled edge.
  initial begin : bram_model
    logic [31:0] word;
    logic [12:0] idx;
    for (int i = 0; i < 8192; i++) bram_mem[i] = 32'h0;
    bram_din = 32'h0;
    forever begin
      @(posedge clk);
      if (bram_en) begin
        idx  = bram_addr[14:2];
        word = bram_mem[idx];
        bram_din <= word;
        for (int b = 0; b < 4; b++)
          if (bram_wen[b]) word[8*b +: 8] = bram_dout[8*b +: 8];
        bram_mem[idx] = word;
      end
    end
  end

  // Monitor: pops the scoreboard on every Ack and checks ordering and spacing.
  initial begin : monitor
    exp_t        e;
    logic [31:0] exp_rd [2];
    logic        ack [2];
    logic        err [2];
    logic [31:0] rd [2];
    int          last_m, last_cyc, cyc;
    bit          have_prev, has;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    last_m = 1; last_cyc = 0; cyc = 0; have_prev = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
        last_m = 1; have_prev = 1'b0;
      end else begin
        cyc++;
        ack[0] = m0_ack; err[0] = m0_err; rd[0] = m0_rdata;
        ack[1] = m1_ack; err[1] = m1_err; rd[1] = m1_rdata;
        if (bram_en) begin
          chk("bram_addr_in_range", 32'(bram_addr < 32'h0000_8000), 32'd1);
          chk("bram_addr_aligned", 32'(bram_addr[1:0]), 32'd0);
        end
        if (m0_ack || m1_ack) chk("ack_overlap", 32'(m0_ack & m1_ack), 32'd0);
        for (int m = 0; m < 2; m++) begin
          if (ack[m]) begin
            has = (m == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            chk($sformatf("m%0d_ack_expected", m), 32'(has), 32'd1);
            if (has) begin
              if (m == 0) e = sb0.pop_front();
              else        e = sb1.pop_front();
              chk($sformatf("m%0d_err", m), 32'(err[m]), 32'(e.err));
              if (e.is_rd && !e.err) exp_rd[m] = e.rdata;
              chk($sformatf("m%0d_rdata", m), rd[m], exp_rd[m]);
            end
            if (contend) begin
              chk("grant_alternates", 32'(m), 32'(1 - last_m));
              if (have_prev) chk("ack_spacing", 32'(cyc - last_cyc), 32'd3);
            end
            last_m = m; last_cyc = cyc; have_prev = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive(input int m, input logic req, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // Wait (bounded) for master m's Ack, counting cycles and BRAM enables seen.
  task automatic wait_ack(input int m, input int limit, output int n,
                          output int en_cnt, output logic [31:0] en_addr);
    logic a;
    n = 0; en_cnt = 0; en_addr = 32'h0; a = 1'b0;
    while (!a && n < limit) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bram_en) begin
        en_cnt++;
        en_addr = bram_addr;
      end
      a = (m == 0) ? m0_ack : m1_ack;
    end
    chk($sformatf("m%0d_ack_seen", m), 32'(a), 32'd1);
  endtask

  task automatic xact(input int m, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wd, input int exp_lat, input int exp_en,
                      input logic [31:0] exp_en_addr, input bit hold);
    exp_t        e;
    int          n, ec;
    logic [31:0] ea;
    e = model_xact(we, addr, wd);
    @(posedge clk);
    #1;
    if (m == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    drive(m, 1'b1, we, addr, wd);
    wait_ack(m, 20, n, ec, ea);
    if (exp_lat >= 0) chk("req_to_ack_latency", 32'(n), 32'(exp_lat));
    if (exp_en >= 0) begin
      chk("bram_en_cycles", 32'(ec), 32'(exp_en));
      if (exp_en > 0) chk("bram_addr_issued", ea, exp_en_addr);
    end
    if (!hold) drive(m, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic rand_xact(input int m);
    logic [3:0]  we;
    logic [31:0] addr, wd;
    we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    wd = $urandom();
    if ($urandom_range(0, 5) == 0) begin
      case ($urandom_range(0, 2))
        0:       addr = 32'h0000_8000;
        1:       addr = 32'hFFFF_FFFC;
        default: addr = 32'h0000_8000 + 32'($urandom_range(0, 32'h00FF_0000));
      endcase
    end else begin
      addr = ((m == 0) ? 32'h0000_0100 : 32'h0000_7F80) + 32'($urandom_range(0, 127));
    end
    xact(m, we, addr, wd, -1, -1, 32'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bram_en"},   32'(bram_en),  32'd0);
    chk({tag, "_bram_wen"},  32'(bram_wen), 32'd0);
    chk({tag, "_bram_addr"}, bram_addr,     32'd0);
    chk({tag, "_bram_dout"}, bram_dout,     32'd0);
    chk({tag, "_m0_ack"},    32'(m0_ack),   32'd0);
    chk({tag, "_m1_ack"},    32'(m1_ack),   32'd0);
    chk({tag, "_m0_err"},    32'(m0_err),   32'd0);
    chk({tag, "_m1_err"},    32'(m1_err),   32'd0);
    chk({tag, "_m0_rdata"},  m0_rdata,      32'd0);
    chk({tag, "_m1_rdata"},  m1_rdata,      32'd0);
  endtask

  initial begin : main
    exp_t        e;
    int          n, ec;
    logic [31:0] ea;
    rst_n = 1'b0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Full-word write then unaligned read of the same word.
    xact(0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1, 32'h0000_0010, 1'b0);
    repeat (2) @(posedge clk);
    xact(0, 4'h0, 32'h0000_0012, 32'h0, 3, 1, 32'h0000_0010, 1'b0);
    chk("m0_read_back", m0_rdata, 32'hDEAD_BEEF);

    // Single byte lane merged into an existing word.
    xact(0, 4'hF, 32'h0000_0020, 32'h1122_3344, 3, 1, 32'h0000_0020, 1'b0);
    xact(0, 4'b0100, 32'h0000_0020, 32'h00AA_0000, 3, 1, 32'h0000_0020, 1'b0);
    xact(0, 4'h0, 32'h0000_0020, 32'h0, 3, 1, 32'h0000_0020, 1'b0);
    chk("byte_lane_merge", m0_rdata, 32'h11AA_3344);

    // Last in-range word, then first out-of-range byte on M1.
    xact(1, 4'hF, 32'h0000_7FFC, 32'hCAFE_F00D, 3, 1, 32'h0000_7FFC, 1'b0);
    xact(1, 4'h0, 32'h0000_7FFF, 32'h0, 3, 1, 32'h0000_7FFC, 1'b0);
    xact(1, 4'h0, 32'h0000_8000, 32'h0, 3, 0, 32'h0, 1'b0);
    chk("m1_rdata_held_after_err", m1_rdata, 32'hCAFE_F00D);

    // Request held through its Ack: re-grant one edge later, next Ack 4 cycles on.
    xact(0, 4'h0, 32'h0000_0010, 32'h0, 3, 1, 32'h0000_0010, 1'b1);
    e = model_xact(4'h0, 32'h0000_0010, 32'h0);
    sb0.push_back(e);
    wait_ack(0, 20, n, ec, ea);
    chk("held_req_ack_gap", 32'(n), 32'd4);
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset while the BRAM access is being issued; the transaction must vanish.
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n = 0;
    while (!bram_en && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_test_issue_seen", 32'(bram_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_issue_reset");
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);

    // Both masters request from the same edge, back to back, 50 each.
    contend = 1'b1;
    fork
      begin
        for (int i = 0; i < 50; i++) rand_xact(0);
      end
      begin
        for (int j = 0; j < 50; j++) rand_xact(1);
      end
    join
    contend = 1'b0;
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
